// File: rtl/icache_line_fill_pkg.sv
// Shared types, tag fields and sizing helpers for the icache line-fill unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_fill_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } fill_state_t;

   // Request tag layout: {read/write, transaction type, 8-bit id}
   localparam logic       TAG_READ        = 1'b1;
   localparam logic [3:0] TAG_TYPE_MEMORY = 4'b0001;

   // Number of bus beats that make up one cache line
   function automatic int fill_beats(input int line_bytes, input int data_width);
      return (line_bytes * 8) / data_width;
   endfunction

   // Beat counter width; never narrower than one bit
   function automatic int fill_cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/icache_line_fill.sv
// Line-fill unit: one miss -> one tagged bus read -> BEATS beats -> one-cycle fill pulse.
// Latency: reqcyc one cycle after miss accept; fill_valid one cycle after the last beat.
// Backpressure: one miss in flight; miss_ready only in IDLE; request held until reqack.
module icache_line_fill
   import icache_fill_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int LINE_BYTES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    miss_valid,
   input  logic [ADDR_WIDTH-1:0]   miss_addr,
   output logic                    miss_ready,
   output logic                    fill_valid,
   output logic [ADDR_WIDTH-1:0]   fill_addr,
   output logic [LINE_BYTES*8-1:0] fill_data,
   output logic                    busy,
   output logic [DATA_WIDTH-1:0]   req,
   output logic [TAG_WIDTH-1:0]    reqtag,
   output logic                    reqcyc,
   input  logic                    reqack,
   input  logic [DATA_WIDTH-1:0]   resp,
   input  logic [TAG_WIDTH-1:0]    resptag,
   input  logic                    respcyc,
   output logic                    respack
);

   localparam int BEATS = fill_beats(LINE_BYTES, DATA_WIDTH);
   localparam int CNT_W = fill_cnt_width(BEATS);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
   localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [12:0]           READ_TAG  = {TAG_READ, TAG_TYPE_MEMORY, 8'h00};

   fill_state_t             state;
   logic [CNT_W-1:0]        beat_cnt;
   logic [ADDR_WIDTH-1:0]   line_addr;
   logic [DATA_WIDTH-1:0]   line_buf [BEATS];

   // Only one request is ever outstanding, so the response tag carries no information
   logic unused_resptag;
   assign unused_resptag = ^resptag;

   // Beats are consumed only while collecting the response
   assign respack = (state == RESP) && respcyc;

   assign fill_addr = line_addr;

   for (genvar i = 0; i < BEATS; i++) begin : g_line
      assign fill_data[DATA_WIDTH*i +: DATA_WIDTH] = line_buf[i];
   end

   // Fill sequencer with registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         line_addr  <= '0;
         miss_ready <= 1'b0;
         busy       <= 1'b0;
         reqcyc     <= 1'b0;
         req        <= '0;
         reqtag     <= '0;
         fill_valid <= 1'b0;
         for (int i = 0; i < BEATS; i++) begin
            line_buf[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               fill_valid <= 1'b0;
               if (miss_valid && miss_ready) begin
                  line_addr  <= miss_addr & ~LINE_MASK;
                  req        <= DATA_WIDTH'(miss_addr & ~LINE_MASK);
                  reqtag     <= TAG_WIDTH'(READ_TAG);
                  reqcyc     <= 1'b1;
                  beat_cnt   <= '0;
                  busy       <= 1'b1;
                  miss_ready <= 1'b0;
                  state      <= REQ;
               end else begin
                  miss_ready <= 1'b1;
               end
            end
            REQ: begin
               // A beat presented alongside reqack is not consumed here
               if (reqack) begin
                  reqcyc <= 1'b0;
                  state  <= RESP;
               end
            end
            RESP: begin
               if (respcyc) begin
                  line_buf[beat_cnt] <= resp;
                  beat_cnt           <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) begin
                     fill_valid <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               fill_valid <= 1'b0;
               busy       <= 1'b0;
               miss_ready <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: vector table, hand sequences, random fills.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_icache_line_fill;

   logic         clk = 1'b0;
   logic         reset;
   logic         miss_valid;
   logic [63:0]  miss_addr;
   logic         miss_ready;
   logic         fill_valid;
   logic [63:0]  fill_addr;
   logic [511:0] fill_data;
   logic         busy;
   logic [63:0]  req;
   logic [12:0]  reqtag;
   logic         reqcyc;
   logic         reqack;
   logic [63:0]  resp;
   logic [12:0]  resptag;
   logic         respcyc;
   logic         respack;

   int checks = 0;
   int errors = 0;

   localparam logic [12:0] EXP_TAG = 13'h1100;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] exp_la;
      int          ack_delay;
      int          gap_at;     // beat index preceded by the gap; 8 means no gap
      int          gap_len;
      bit          hold_next;  // keep the next miss asserted during this fill
   } vec_t;

   vec_t         vecs [5];
   logic [63:0]  beat_q [8];
   logic [511:0] last_line;

   icache_line_fill dut (
      .clk        (clk),
      .reset      (reset),
      .miss_valid (miss_valid),
      .miss_addr  (miss_addr),
      .miss_ready (miss_ready),
      .fill_valid (fill_valid),
      .fill_addr  (fill_addr),
      .fill_data  (fill_data),
      .busy       (busy),
      .req        (req),
      .reqtag     (reqtag),
      .reqcyc     (reqcyc),
      .reqack     (reqack),
      .resp       (resp),
      .resptag    (resptag),
      .respcyc    (respcyc),
      .respack    (respack)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected line is simply the beats placed in ascending slots
   function automatic logic [511:0] model_line();
      logic [511:0] l;
      l = '0;
      for (int i = 0; i < 8; i++) l[64*i +: 64] = beat_q[i];
      return l;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic run_fill(input logic [63:0] addr, input logic [63:0] exp_la,
                           input int ack_delay, input int gap_at, input int gap_len,
                           input bit hold, input logic [63:0] next_addr);
      logic [511:0] exp_line;
      exp_line   = model_line();
      miss_valid = 1'b1;
      miss_addr  = addr;
      tick();
      chk("req_valid", reqcyc, 1);
      chk("req_addr", req, exp_la);
      chk("req_tag", reqtag, EXP_TAG);
      chk("miss_ready_req", miss_ready, 0);
      chk("busy_req", busy, 1);
      miss_valid = 1'b0;
      miss_addr  = rnd64();
      for (int d = 0; d < ack_delay; d++) begin
         reqack  = 1'b0;
         respcyc = 1'b1;
         resp    = rnd64();
         #1 chk("respack_in_req", respack, 0);
         tick();
         chk("req_hold_valid", reqcyc, 1);
         chk("req_hold_addr", req, exp_la);
         chk("req_hold_tag", reqtag, EXP_TAG);
      end
      reqack  = 1'b1;
      respcyc = 1'b1;
      resp    = rnd64();
      #1 chk("respack_with_reqack", respack, 0);
      tick();
      chk("req_dropped", reqcyc, 0);
      reqack = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (b == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               respcyc = 1'b0;
               #1 chk("respack_gap", respack, 0);
               tick();
               chk("no_fill_in_gap", fill_valid, 0);
            end
         end
         respcyc    = 1'b1;
         resp       = beat_q[b];
         miss_valid = hold;
         miss_addr  = hold ? next_addr : rnd64();
         #1 chk("respack_beat", respack, 1);
         tick();
         if (b < 7) chk("no_early_fill", fill_valid, 0);
      end
      respcyc = 1'b0;
      chk("fill_pulse", fill_valid, 1);
      chk("fill_addr", fill_addr, exp_la);
      chk("fill_data", fill_data, exp_line);
      chk("miss_ready_done", miss_ready, 0);
      tick();
      chk("fill_one_cycle", fill_valid, 0);
      chk("miss_ready_idle", miss_ready, 1);
      chk("busy_idle", busy, 0);
      chk("no_new_req_yet", reqcyc, 0);
      chk("fill_data_retained", fill_data, exp_line);
      last_line = exp_line;
   endtask

   initial begin
      vecs[0] = '{64'h1234, 64'h1200, 0, 8, 0, 1'b0};
      vecs[1] = '{64'h2fff, 64'h2fc0, 5, 8, 0, 1'b0};
      vecs[2] = '{64'h8040, 64'h8040, 1, 4, 3, 1'b0};
      vecs[3] = '{64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffc0, 0, 0, 2, 1'b1};
      vecs[4] = '{64'h0000_0000_dead_beef, 64'h0000_0000_dead_bec0, 2, 7, 1, 1'b0};

      reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; reqack = 1'b0;
      resp = '0; resptag = '0; respcyc = 1'b0;
      tick(); tick(); tick();
      chk("rst_miss_ready", miss_ready, 0);
      chk("rst_fill_valid", fill_valid, 0);
      chk("rst_fill_addr", fill_addr, 0);
      chk("rst_fill_data", fill_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req", req, 0);
      chk("rst_reqtag", reqtag, 0);
      chk("rst_reqcyc", reqcyc, 0);
      chk("rst_respack", respack, 0);
      reset = 1'b0;
      tick();
      chk("miss_ready_after_reset", miss_ready, 1);

      // Spurious response traffic while idle
      respcyc = 1'b1; resp = 64'hdead;
      #1 chk("respack_idle", respack, 0);
      tick();
      chk("idle_no_store", fill_data, 0);
      respcyc = 1'b0;

      // Vector table
      for (int i = 0; i < 5; i++) begin
         int n;
         n = (i < 4) ? i + 1 : i;
         for (int b = 0; b < 8; b++) beat_q[b] = (i == 0) ? 64'(b) : rnd64();
         run_fill(vecs[i].addr, vecs[i].exp_la, vecs[i].ack_delay, vecs[i].gap_at,
                  vecs[i].gap_len, vecs[i].hold_next, vecs[n].addr);
      end

      // Spurious beat after a fill leaves the line alone
      respcyc = 1'b1; resp = rnd64();
      #1 chk("respack_idle2", respack, 0);
      tick();
      chk("line_kept_idle", fill_data, last_line);
      respcyc = 1'b0;

      // Reset in the middle of the response
      miss_valid = 1'b1; miss_addr = 64'h3010;
      tick();
      miss_valid = 1'b0; reqack = 1'b1;
      tick();
      reqack = 1'b0;
      for (int b = 0; b < 4; b++) begin
         respcyc = 1'b1; resp = rnd64();
         tick();
      end
      reset = 1'b1;
      tick();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_reqcyc", reqcyc, 0);
      chk("mid_rst_fill_valid", fill_valid, 0);
      chk("mid_rst_respack", respack, 0);
      chk("mid_rst_line", fill_data, 0);
      reset = 1'b0; respcyc = 1'b0;
      tick();
      chk("mid_rst_no_fill", fill_valid, 0);
      chk("mid_rst_ready", miss_ready, 1);
      for (int b = 0; b < 8; b++) beat_q[b] = rnd64();
      run_fill(64'h4000, 64'h4000, 0, 8, 0, 1'b0, 64'h0);

      // Randomised fills against the line model
      for (int r = 0; r < 6; r++) begin
         logic [63:0] a;
         a = rnd64();
         for (int b = 0; b < 8; b++) beat_q[b] = rnd64();
         run_fill(a, a & ~64'h3f, $urandom_range(0, 3), $urandom_range(0, 8),
                  $urandom_range(1, 3), 1'b0, 64'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
